// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - Shared constants, state encoding and flag packing for the mult/div unit
package alu_muldiv_pkg;

  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  localparam int FLAG_DZ    = 2;
  localparam int FLAG_HISIG = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [2:0] pack_flags(input logic dz, input logic hisig, input logic zero);
    logic [2:0] f;
    f             = '0;
    f[FLAG_DZ]    = dz;
    f[FLAG_HISIG] = hisig;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - One-bit-per-cycle unsigned shift-add multiplier / restoring divider
module muldiv_iter_core
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

  logic [WIDTH:0]   alu_a, alu_b;
  logic [WIDTH+1:0] alu_y;
  logic             borrow;
  logic [WIDTH-1:0] hi_d, lo_d;

  // hi:lo is one shift register; lo starts as multiplier or dividend and fills with product/quotient bits
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_y  = '0;
    borrow = 1'b0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (div_q) begin
      alu_a  = {hi_q, lo_q[WIDTH-1]};
      alu_b  = {1'b0, b_q};
      alu_y  = {1'b0, alu_a} - {1'b0, alu_b};
      borrow = alu_y[WIDTH+1];
      hi_d   = borrow ? alu_a[WIDTH-1:0] : alu_y[WIDTH-1:0];
      lo_d   = {lo_q[WIDTH-2:0], ~borrow};
    end else begin
      alu_a  = {1'b0, hi_q};
      alu_b  = lo_q[0] ? {1'b0, b_q} : '0;
      alu_y  = {1'b0, alu_a} + {1'b0, alu_b};
      hi_d   = alu_y[WIDTH:1];
      lo_d   = {alu_y[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= op_a;
      b_q   <= op_b;
      div_q <= mode_div;
      cnt_q <= CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done   = (cnt_q == CNT_W'(1));
  assign res_hi = hi_q;
  assign res_lo = lo_q;

endmodule

// File: rtl/alu_muldiv_seq.sv
// rtl/alu_muldiv_seq.sv - Iterative MIPS mult/div unit owning architectural HI/LO with valid/ready handshakes
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [2:0]       flags,
  output logic             illegal
);

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q, result_q;
  logic [2:0]       flags_q;
  logic             illegal_q, signed_q, div_q, neg_q, rem_neg_q;

  logic [5:0]         funct;
  logic               op_zero, is_md, is_mv, is_signed_in, is_div_in;
  logic               a_neg, b_neg, accept, core_start, core_done;
  logic [WIDTH-1:0]   a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod_m, prod_s;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               fix_hisig;
  logic               unused_instr;

  assign funct        = instruction[5:0];
  assign op_zero      = (instruction[31:26] == 6'd0);
  assign unused_instr = ^instruction[25:6];
  assign is_md        = op_zero && (funct inside {MULT, MULTU, DIV, DIVU});
  assign is_mv        = op_zero && (funct inside {MFHI, MTHI, MFLO, MTLO});
  assign is_signed_in = (funct == MULT) || (funct == DIV);
  assign is_div_in    = (funct == DIV) || (funct == DIVU);
  assign a_neg        = is_signed_in && reg_a[WIDTH-1];
  assign b_neg        = is_signed_in && reg_b[WIDTH-1];
  assign a_mag        = a_neg ? -reg_a : reg_a;
  assign b_mag        = b_neg ? -reg_b : reg_b;

  assign in_ready   = rst_n && (state_q == IDLE);
  assign accept     = in_valid && in_ready;
  assign core_start = accept && is_md && !(is_div_in && (reg_b == '0));

  muldiv_iter_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (core_start),
    .mode_div(is_div_in),
    .op_a    (a_mag),
    .op_b    (b_mag),
    .done    (core_done),
    .res_hi  (core_hi),
    .res_lo  (core_lo)
  );

  // Sign correction: product/quotient negate on differing signs, remainder follows the dividend
  assign prod_m    = {core_hi, core_lo};
  assign prod_s    = neg_q ? -prod_m : prod_m;
  assign fix_hi    = div_q ? (rem_neg_q ? -core_hi : core_hi) : prod_s[2*WIDTH-1:WIDTH];
  assign fix_lo    = div_q ? (neg_q ? -core_lo : core_lo) : prod_s[WIDTH-1:0];
  assign fix_hisig = !div_q && (signed_q ? (fix_hi != {WIDTH{fix_lo[WIDTH-1]}})
                                         : (fix_hi != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      signed_q  <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            illegal_q <= 1'b0;
            signed_q  <= is_signed_in;
            div_q     <= is_div_in;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            if (core_start) begin
              state_q <= CALC;
            end else begin
              state_q <= DONE;
              if (!is_md && !is_mv) begin
                illegal_q <= 1'b1;
                result_q  <= '0;
                flags_q   <= pack_flags(1'b0, 1'b0, 1'b1);
              end else if (is_md) begin
                result_q <= lo_q;
                flags_q  <= pack_flags(1'b1, 1'b0, {hi_q, lo_q} == '0);
              end else begin
                case (funct)
                  MFHI: begin
                    result_q <= hi_q;
                    flags_q  <= pack_flags(1'b0, 1'b0, hi_q == '0);
                  end
                  MFLO: begin
                    result_q <= lo_q;
                    flags_q  <= pack_flags(1'b0, 1'b0, lo_q == '0);
                  end
                  MTHI: begin
                    hi_q     <= reg_a;
                    result_q <= '0;
                    flags_q  <= pack_flags(1'b0, 1'b0, 1'b1);
                  end
                  default: begin
                    lo_q     <= reg_a;
                    result_q <= '0;
                    flags_q  <= pack_flags(1'b0, 1'b0, 1'b1);
                  end
                endcase
              end
            end
          end
        end
        CALC: begin
          if (core_done) state_q <= FIX;
        end
        FIX: begin
          hi_q     <= fix_hi;
          lo_q     <= fix_lo;
          result_q <= fix_lo;
          flags_q  <= pack_flags(1'b0, fix_hisig, {fix_hi, fix_lo} == '0);
          state_q  <= DONE;
        end
        default: begin
          if (out_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb/tb_alu_muldiv_seq.sv - Directed self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;

  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] instruction, reg_a, reg_b, result, hi, lo;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instruction(instruction),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .hi         (hi),
    .lo         (lo),
    .flags      (flags),
    .illegal    (illegal)
  );

  task automatic issue_wait(input logic [31:0] instr, input logic [31:0] a,
                            input logic [31:0] b, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_in_ready got %b want 1", in_ready); end
    instruction = instr; reg_a = a; reg_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; reg_a = '0; reg_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_hilo got %h want 0", {hi, lo}); end
    checks++; if ({result, flags, illegal} !== 36'h0) begin errors++; $display("FAIL rst_outs got %h want 0", {result, flags, illegal}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_mult();
    int lat;
    issue_wait(I_MULT, 32'hFFFF_FFFD, 32'd5, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    checks++; if (result !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_result got %h want fffffff1", result); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL mult_flags got %b want 000", flags); end
    finish_op();
    issue_wait(I_MULT, 32'h8000_0000, 32'h8000_0000, lat);
    checks++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mult_min_prod got %h want 4000000000000000", {hi, lo}); end
    checks++; if (flags !== 3'b010) begin errors++; $display("FAIL mult_min_flags got %b want 010", flags); end
    finish_op();
  endtask

  task automatic test_multu_mfhi();
    int lat;
    issue_wait(I_MULTU, 32'hFFFF_FFFF, 32'd2, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL multu_latency got %0d want 34", lat); end
    checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_prod got %h want 00000001fffffffe", {hi, lo}); end
    checks++; if (flags !== 3'b010) begin errors++; $display("FAIL multu_flags got %b want 010", flags); end
    finish_op();
    issue_wait(I_MFHI, 32'h0, 32'h0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL mfhi_latency got %0d want 1", lat); end
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL mfhi_result got %h want 00000001", result); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL mfhi_flags got %b want 000", flags); end
    finish_op();
  endtask

  task automatic test_div();
    int lat;
    issue_wait(I_DIV, 32'hFFFF_FFF9, 32'd2, lat);
    checks++; if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
    checks++; if ({result, flags} !== {32'hFFFF_FFFD, 3'b000}) begin errors++; $display("FAIL div_res_flags got %h want fffffffd/000", {result, flags}); end
    finish_op();
    issue_wait(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf got %h want 0000000080000000", {hi, lo}); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL div_ovf_flags got %b want 000", flags); end
    finish_op();
    issue_wait(I_DIVU, 32'd100, 32'd7, lat);
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_hilo got %h want 000000020000000e", {hi, lo}); end
    finish_op();
  endtask

  task automatic test_div_by_zero();
    int lat;
    issue_wait(I_MTHI, 32'hAA, 32'h0, lat);
    checks++; if ({lat, hi, result, flags} !== {32'd1, 32'hAA, 32'h0, 3'b001}) begin errors++; $display("FAIL mthi got lat=%0d hi=%h res=%h fl=%b want 1/aa/0/001", lat, hi, result, flags); end
    finish_op();
    issue_wait(I_MTLO, 32'h55, 32'h0, lat);
    checks++; if (lo !== 32'h55) begin errors++; $display("FAIL mtlo got %h want 00000055", lo); end
    finish_op();
    issue_wait(I_DIVU, 32'h1234, 32'h0, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (flags !== 3'b100) begin errors++; $display("FAIL dz_flags got %b want 100", flags); end
    checks++; if ({hi, lo, result} !== {32'hAA, 32'h55, 32'h55}) begin errors++; $display("FAIL dz_hilo got %h want aa/55/55", {hi, lo, result}); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    issue_wait(I_MFLO, 32'h0, 32'h0, lat);
    instruction = I_MTLO; reg_a = 32'h99; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL bp_handshake[%0d] got %b want 10", i, {out_valid, in_ready}); end
      checks++; if ({result, flags, lo} !== {32'h55, 3'b000, 32'h55}) begin errors++; $display("FAIL bp_hold[%0d] got %h want 55/000/55", i, {result, flags, lo}); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, lo} !== {2'b01, 32'h55}) begin errors++; $display("FAIL bp_after_hs got %h want 1/00000055", {out_valid, in_ready, lo}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if ({out_valid, lo} !== {1'b1, 32'h99}) begin errors++; $display("FAIL bp_accept got %h want 1/00000099", {out_valid, lo}); end
    finish_op();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    instruction = I_MULT; reg_a = 32'd7; reg_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if ({out_valid, in_ready, hi, lo} !== {2'b00, 32'hAA, 32'h99}) begin errors++; $display("FAIL calc_old_hilo got %h want 0/0/aa/99", {out_valid, in_ready, hi, lo}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, hi, lo} !== 65'h0) begin errors++; $display("FAIL mid_rst got %h want 0", {out_valid, hi, lo}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue_wait(I_MFLO, 32'h0, 32'h0, lat);
    checks++; if ({lat, result, flags} !== {32'd1, 32'h0, 3'b001}) begin errors++; $display("FAIL mflo_after_rst got lat=%0d res=%h fl=%b want 1/0/001", lat, result, flags); end
    finish_op();
    issue_wait(32'h0000_0020, 32'h1, 32'h2, lat);
    checks++; if ({illegal, result, flags} !== {1'b1, 32'h0, 3'b001}) begin errors++; $display("FAIL illegal_funct got %b/%h/%b want 1/0/001", illegal, result, flags); end
    finish_op();
    issue_wait(32'hFC00_0018, 32'h3, 32'h4, lat);
    checks++; if ({lat, illegal, hi, lo} !== {32'd1, 1'b1, 64'h0}) begin errors++; $display("FAIL illegal_opcode got lat=%0d ill=%b hilo=%h want 1/1/0", lat, illegal, {hi, lo}); end
    finish_op();
    issue_wait(I_MFHI, 32'h0, 32'h0, lat);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear got %b want 0", illegal); end
    finish_op();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mult();
    test_multu_mfhi();
    test_div();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
